// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types for the JK bank driver.
// FSM state encoding and {j,k} excitation codes.
package jk_drv_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_DRIVE  = S_DRIVE,
    ST_SETTLE = S_SETTLE,
    ST_CHECK  = S_CHECK,
    ST_ERR    = S_ERR
  } state_t;

  // Codes are {j,k}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_bank_driver_excite.sv
// jk_excite: per-bit J/K excitation from current q to target tgt (comb).
// Ports: q, tgt in (W); j, k out (W). Macro JK_TOGGLE_ENC_EN selects toggle codes.
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic       chg;
    logic [1:0] code;

    assign chg = q[i] ^ tgt[i];

    always_comb begin
      code = JK_HOLD;
      unique case (1'b1)
        !chg: code = JK_HOLD;
`ifdef JK_TOGGLE_ENC_EN
        chg && tgt[i]:  code = JK_TGL;
        chg && !tgt[i]: code = JK_TGL;
`else
        chg && tgt[i]:  code = JK_SET;
        chg && !tgt[i]: code = JK_RST;
`endif
        default: code = JK_HOLD;
      endcase
    end

    assign j[i] = code[1];
    assign k[i] = code[0];
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK bank to a target word, verifies, retries.
// Ports: clk, rst (async low), tgt_*, q_fb, j, k, done, err, err_clr.
// Macro JK_TOGGLE_ENC_EN: changed bits use toggle instead of set/reset.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int W          = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] tgt_data,
  input  logic         tgt_valid,
  output logic         tgt_ready,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         done,
  output logic         err,
  input  logic         err_clr
);

  localparam int SW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [SW-1:0] SETTLE_LD =
    SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRY);

  state_t        state;
  logic [W-1:0]  tgt_r;
  logic [SW-1:0] settle_cnt;
  logic [RW-1:0] retry_cnt;

  logic [W-1:0]  exc_tgt;
  logic [W-1:0]  exc_j;
  logic [W-1:0]  exc_k;

  // One excitation unit serves both the initial
  // load (live target) and retries (held target).
  assign exc_tgt = (state == ST_IDLE) ? tgt_data
                                      : tgt_r;

  jk_excite #(
    .W(W)
  ) u_excite (
    .q  (q_fb),
    .tgt(exc_tgt),
    .j  (exc_j),
    .k  (exc_k)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tgt_r      <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
      j          <= '0;
      k          <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      tgt_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tgt_valid) begin
            tgt_r     <= tgt_data;
            j         <= exc_j;
            k         <= exc_k;
            retry_cnt <= '0;
            tgt_ready <= 1'b0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          j          <= '0;
          k          <= '0;
          settle_cnt <= SETTLE_LD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (q_fb == tgt_r) begin
            done      <= 1'b1;
            tgt_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 1'b1;
            j         <= exc_j;
            k         <= exc_k;
            state     <= ST_DRIVE;
          end else begin
            err   <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            err       <= 1'b0;
            tgt_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          j         <= '0;
          k         <= '0;
          tgt_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed + random checks of jk_bank_driver
// against a JK bank model with injectable faults.
module tb_jk_bank_driver;

  localparam int W  = 4;
  localparam int SC = 1;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         tgt_valid = 1'b0;
  logic         tgt_ready;
  logic [W-1:0] q_fb;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         done;
  logic         err;
  logic         err_clr = 1'b0;

  int passed = 0;
  int total  = 0;

  jk_bank_driver #(
    .W(W), .SETTLE_CYC(SC), .MAX_RETRY(MR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_data (tgt_data),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Bank of ideal JK cells with faults:
  // stk bits never change; ign_req bits skip
  // their next non-hold strobe (armed via ign_seq).
  logic [W-1:0] bank = '0;
  logic [W-1:0] stk = '0;
  logic [W-1:0] ign_req = '0;
  int           ign_seq = 0;
  int           ign_seen = 0;
  logic [W-1:0] pend = '0;

  assign q_fb = bank;

  always @(posedge clk) begin
    logic [W-1:0] p;
    logic [W-1:0] nb;
    p  = pend;
    nb = bank;
    if (ign_seq != ign_seen) begin
      p = ign_req;
      ign_seen <= ign_seq;
    end
    for (int i = 0; i < W; i++) begin
      if ((j[i] | k[i]) && !stk[i]) begin
        if (p[i]) p[i] = 1'b0;
        else begin
          case ({j[i], k[i]})
            2'b01:   nb[i] = 1'b0;
            2'b10:   nb[i] = 1'b1;
            2'b11:   nb[i] = ~bank[i];
            default: nb[i] = bank[i];
          endcase
        end
      end
    end
    pend <= p;
    bank <= nb;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  // Expected {j,k}: only changed bits are excited.
  function automatic logic [2*W-1:0] ref_exc(
    input logic [W-1:0] q, input logic [W-1:0] t);
    logic [W-1:0] chg;
    chg = q ^ t;
`ifdef JK_TOGGLE_ENC_EN
    return {chg, chg};
`else
    return {chg & t, chg & ~t};
`endif
  endfunction

  task automatic arm_ign(input logic [W-1:0] m);
    ign_req = m;
    ign_seq++;
  endtask

  // Called at a negedge while DUT is idle.
  task automatic start(input logic [W-1:0] t,
                       input bit keep);
    int n;
    n = 0;
    tgt_data  = t;
    tgt_valid = 1'b1;
    while (!tgt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(tgt_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) tgt_valid = 1'b0;
  endtask

  // Starts at the negedge inside the first strobe
  // cycle; ends at the negedge of done or err.
  task automatic run_seq(input logic [W-1:0] t,
                         output int strobes,
                         output bit got_err);
    logic [W-1:0]   cur;
    logic [2*W-1:0] e;
    strobes = 0;
    got_err = 1'b0;
    for (int a = 0; a <= MR; a++) begin
      e = ref_exc(q_fb, t);
      chk("strobe_j", 32'(j), 32'(e[2*W-1:W]));
      chk("strobe_k", 32'(k), 32'(e[W-1:0]));
      chk("busy_ready", 32'(tgt_ready), 32'd0);
      chk("busy_done", 32'(done), 32'd0);
      strobes++;
      for (int s = 0; s < SC; s++) begin
        @(negedge clk);
        chk("settle_jk", 32'({j, k}), 32'd0);
      end
      @(negedge clk);
      chk("check_jk", 32'({j, k}), 32'd0);
      chk("check_done", 32'(done), 32'd0);
      cur = q_fb;
      @(negedge clk);
      if (cur == t) begin
        chk("done", 32'(done), 32'd1);
        chk("done_ready", 32'(tgt_ready), 32'd1);
        return;
      end
      if (a == MR) begin
        chk("err", 32'(err), 32'd1);
        chk("err_ready", 32'(tgt_ready), 32'd0);
        chk("err_jk", 32'({j, k}), 32'd0);
        got_err = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int           ns;
    bit           ge;
    logic [W-1:0] t;
    logic [W-1:0] m;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Clean write 0000 -> 1010
    start(4'b1010, 1'b0);
    run_seq(4'b1010, ns, ge);
    chk("clean_strobes", 32'(ns), 32'd1);
    chk("clean_bank", 32'(q_fb), 32'b1010);

    // Move to 0110, then rewrite the same value
    start(4'b0110, 1'b0);
    run_seq(4'b0110, ns, ge);
    start(4'b0110, 1'b0);
    chk("same_j", 32'(j), 32'd0);
    chk("same_k", 32'(k), 32'd0);
    run_seq(4'b0110, ns, ge);
    chk("same_strobes", 32'(ns), 32'd1);
    chk("same_bank", 32'(q_fb), 32'b0110);

    // Bit0 ignored once -> one retry
    arm_ign(4'b0001);
    start(4'b0111, 1'b0);
    run_seq(4'b0111, ns, ge);
    chk("ign_strobes", 32'(ns), 32'd2);
    chk("ign_err", 32'(ge), 32'd0);
    chk("ign_bank", 32'(q_fb), 32'b0111);

    // Bit2 stuck at 1 -> retries exhausted
    stk = 4'b0100;
    start(4'b0011, 1'b0);
    run_seq(4'b0011, ns, ge);
    chk("stk_strobes", 32'(ns), 32'(MR + 1));
    chk("stk_err", 32'(ge), 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_ready", 32'(tgt_ready), 32'd0);
    chk("err_no_strobe", 32'({j, k}), 32'd0);
    tgt_valid = 1'b0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errclr_err", 32'(err), 32'd0);
    chk("errclr_ready", 32'(tgt_ready), 32'd1);
    stk = '0;

    // Back-to-back with valid held
    start(4'b0011, 1'b1);
    run_seq(4'b0011, ns, ge);
    tgt_data = 4'b1100;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    run_seq(4'b1100, ns, ge);
    chk("b2b_strobes", 32'(ns), 32'd1);
    chk("b2b_bank", 32'(q_fb), 32'b1100);

    // Reset in the middle of a strobe
    start(4'b1001, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_j", 32'(j), 32'd0);
    chk("mid_rst_k", 32'(k), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ready", 32'(tgt_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_bank", 32'(q_fb), 32'b1100);
    @(negedge clk);

    // Random targets, occasional dropped bits
    for (int n = 0; n < 24; n++) begin
      t = W'($urandom);
      m = '0;
      if ($urandom_range(0, 2) == 0)
        m = W'($urandom) & (q_fb ^ t);
      if (m != '0) arm_ign(m);
      start(t, 1'b0);
      run_seq(t, ns, ge);
      chk("rnd_strobes", 32'(ns),
          (m != '0) ? 32'd2 : 32'd1);
      chk("rnd_bank", 32'(q_fb), 32'(t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
